// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush generator for the 5-stage MIPS32 pipeline (load-use,
//            branch-operand, divide, cache-miss and exception sequencing).
//            Optional stall/flush counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int REGW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNTW = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            div_startE,
  input  logic            div_readyE,
  input  logic            i_stall,
  input  logic            d_stall,
  input  logic            exceptionM,
  output logic            enF,
  output logic            enD,
  output logic            enE,
  output logic            enM,
  output logic            enW,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            div_go,
  output logic            div_cancel
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNTW-1:0] stall_cnt
  , output logic [CNTW-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t r_state;

  logic w_eq_e;
  logic w_eq_m;
  logic w_lwstall;
  logic w_brstall;
  logic w_memstall;
  logic w_exc;
  logic w_divstall;

  // Register $0 is hard-wired zero and never creates a dependency
  assign w_eq_e = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
  assign w_eq_m = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));

  assign w_lwstall  = memtoregE & regwriteE & w_eq_e;
  assign w_brstall  = branchD & ((regwriteE & w_eq_e) | (memtoregM & w_eq_m));
  assign w_memstall = i_stall | d_stall;
  assign w_exc      = exceptionM & ~i_stall;
  assign w_divstall = ((r_state == S_IDLE) & div_startE) | (r_state == S_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (w_exc) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (div_startE)   r_state <= S_BUSY;
        S_BUSY:  if (div_readyE)   r_state <= S_DONE;
        // Linger until E can actually advance so the same div cannot restart
        S_DONE:  if (!w_memstall)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    enF        = 1'b0;
    enD        = 1'b0;
    enE        = 1'b0;
    enM        = 1'b0;
    enW        = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    div_go     = 1'b0;
    div_cancel = 1'b0;
    if (reset) begin
      div_go     = ~w_exc & (r_state == S_IDLE) & div_startE;
      div_cancel = w_exc & (r_state != S_IDLE);
      if (w_exc) begin
        {enF, enD, enE, enM, enW}      = 5'b11111;
        {flushD, flushE, flushM, flushW} = 4'b1111;
      end else if (w_memstall) begin
        {enF, enD, enE, enM, enW} = 5'b00000;
      end else if (w_divstall) begin
        {enF, enD, enE, enM, enW} = 5'b00011;
        flushM = 1'b1;
      end else if (w_lwstall | w_brstall) begin
        {enF, enD, enE, enM, enW} = 5'b00111;
        flushE = 1'b1;
      end else begin
        {enF, enD, enE, enM, enW} = 5'b11111;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!enD)   stall_cnt <= stall_cnt + 1'b1;
      if (flushD) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_dstall_with_exc: assert property (@(posedge clk) disable iff (!reset)
    !(d_stall && exceptionM));
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage MIPS32 pipeline.
- Drives the enable and flush inputs of every inter-stage enable/flush pipeline register (F→D, D→E, E→M, M→W) plus the PC enable.
- Detects load-use and branch-operand hazards, sequences multi-cycle divide stalls, freezes the pipe on cache stalls, and flushes on committed exceptions.

Parameters:
- REGW, 5, register-index width
- CNTW, 32, width of the stall performance counter (feature only)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- rsD, rtD  in  REGW  source registers of instruction in D
- writeregE, writeregM  in  REGW  destination registers in E and M
- regwriteE, memtoregE, memtoregM  in  1  control bits of E/M instructions
- branchD  in  1  D instruction resolves a branch or jr in D and needs rs/rt now
- div_startE  in  1  div/divu in E
- div_readyE  in  1  divider result valid, 1-cycle pulse
- i_stall, d_stall  in  1  I-cache / D-cache miss in progress
- exceptionM  in  1  exception or eret committed in M
- enF, enD, enE, enM, enW  out  1  register enables; enF = PC enable
- flushD, flushE, flushM, flushW  out  1  register synchronous clears
- div_go  out  1  1-cycle start pulse to divider
- div_cancel  out  1  1-cycle abort pulse to divider

Behaviour:
- While reset=0: divider FSM = IDLE; all en* = 0; all flush* = 0; div_go = div_cancel = 0. First cycle after release: normal combinational evaluation.
- Hazard terms are combinational, all gated by index != 0:
  - lwstall = memtoregE & regwriteE & (writeregE==rsD | writeregE==rtD)
  - brstall = branchD & [(regwriteE & writeregE matches rsD/rtD) | (memtoregM & writeregM matches rsD/rtD)]
  - memstall = i_stall | d_stall
- Divider FSM:
  - IDLE: div_startE & ~exc → BUSY, assert div_go in that cycle.
  - BUSY: hold until div_readyE → DONE. A div_readyE arriving during memstall is still captured.
  - DONE: E is released; leave to IDLE on the first cycle with ~memstall, so the same div in E never retriggers.
  - divstall = (IDLE & div_startE) | BUSY.
- Priority, highest first; outputs are combinational from state + inputs:
  1. exc = exceptionM & ~i_stall.
     - flushD = flushE = flushM = flushW = 1; all en = 1.
     - FSM → IDLE; div_cancel = 1 if state is BUSY or DONE.
     - exceptionM during i_stall waits (M held) until i_stall drops.
     - d_stall is never asserted together with exceptionM; this is a contract, checked by assertion.
  2. memstall: all en = 0, all flush = 0 (full freeze); FSM still advances BUSY → DONE.
  3. divstall: enF = enD = enE = 0, enM = enW = 1, flushM = 1 (bubble into M).
  4. lwstall | brstall: enF = enD = 0, enE = enM = enW = 1, flushE = 1.
  5. Otherwise: all en = 1, all flush = 0.
- Simultaneous div_startE and lwstall: divstall wins; the load-use stall is resolved once E advances.
- Reset asserted mid-BUSY: FSM → IDLE immediately; div_cancel is not asserted (the divider is reset by the same signal).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[CNTW-1:0] and flush_cnt[CNTW-1:0].
  - stall_cnt increments each cycle enD = 0; flush_cnt increments each cycle flushD = 1.
  - Both wrap at 2^CNTW; both clear to 0 on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw $3 in E (memtoregE=1, writeregE=3), rsD=3 → one cycle of enF=enD=0, flushE=1; next cycle all en=1.
- Branch dependency: branchD=1, rtD=5, regwriteE=1, writeregE=5 → stall 1 cycle. Next cycle memtoregM=1, writeregM=5 → stall 1 more cycle. Total 2 stall cycles.
- Divide: div_startE=1, div_readyE after 32 cycles → div_go pulses once, then 33 cycles of enE=0 with flushM=1. DONE cycle has all en=1. No second div_go.
- Divide plus cache miss: d_stall=1 spanning the div_readyE pulse and 3 cycles after → all en=0 during d_stall. FSM holds DONE, then releases E on the first cycle with d_stall=0.
- Exception mid-divide: exceptionM=1 while BUSY → flushD..W=1, div_cancel=1, FSM IDLE next cycle. With i_stall=1, the flush is deferred until i_stall=0.
- Perf counter (macro defined): 3 load-use stalls plus 1 exception → stall_cnt=3, flush_cnt=1. Reset low mid-run → both counters read 0.
